// File: rtl/burst_arb_pkg.sv
// Shared types and constants for the burst arbiter.
package burst_arb_pkg;

    typedef enum logic [0:0] {IDLE, XFER} state_t;

    localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [NUM_REQ-1:0] onehot,
    output logic [ID_W-1:0]    idx
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] cidx;
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = 0;
        cidx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = int'(ptr) + i;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            cidx = ID_W'(cand);
            if (!valid && req[cidx]) begin
                valid        = 1'b1;
                onehot[cidx] = 1'b1;
                idx          = cidx;
            end
        end
    end

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: grants whole bursts and counts beats to the last one.
// Optional per-requester completed-burst counters under BURST_ARB_STATS_EN.
module burst_arbiter
    import burst_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic                     beat_valid,
    input  logic                     beat_ready,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ID_W-1:0]          gnt_id,
    output logic                     burst_active,
    output logic                     burst_last,
    output logic [LEN_W-1:0]         beat_cnt
`ifdef BURST_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0] burst_count
`endif
);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 accept;
    logic                 last;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign accept = (state_q == XFER) && beat_valid && beat_ready;
    assign last   = (state_q == XFER) && (cnt_q == len_q);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = XFER;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_idx;
                    len_d    = req_len[int'(pick_idx)*LEN_W +: LEN_W];
                    cnt_d    = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    if (last) begin
                        // Counter holds at len on the final beat so it never wraps.
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign burst_active = (state_q == XFER);
    assign burst_last   = last;
    assign beat_cnt     = cnt_q;

`ifdef BURST_ARB_STATS_EN
    logic [STATS_W-1:0] stats_q [NUM_REQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                stats_q[i] <= '0;
            end
        end else if (accept && last && (stats_q[gnt_id_q] != {STATS_W{1'b1}})) begin
            stats_q[gnt_id_q] <= stats_q[gnt_id_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_stats_out
        assign burst_count[g*STATS_W +: STATS_W] = stats_q[g];
    end
`endif

endmodule

// File: tb/tb_burst_arbiter.sv
// Self-checking bench for burst_arbiter: scoreboard of expected grants plus per-scenario checks.
module tb_burst_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic                     beat_valid;
    logic                     beat_ready;
    logic [NUM_REQ-1:0]       gnt;
    logic [ID_W-1:0]          gnt_id;
    logic                     burst_active;
    logic                     burst_last;
    logic [LEN_W-1:0]         beat_cnt;
`ifdef BURST_ARB_STATS_EN
    logic [NUM_REQ*16-1:0]    burst_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
    } exp_t;
    exp_t exp_q[$];

    burst_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_len      (req_len),
        .beat_valid   (beat_valid),
        .beat_ready   (beat_ready),
        .gnt          (gnt),
        .gnt_id       (gnt_id),
        .burst_active (burst_active),
        .burst_last   (burst_last),
        .beat_cnt     (beat_cnt)
`ifdef BURST_ARB_STATS_EN
        ,
        .burst_count  (burst_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Waits (bounded) for a grant, then pops the scoreboard and compares.
    task automatic wait_grant(output int waited);
        exp_t            e;
        logic [3:0]      exp_g;
        waited = 0;
        while (!burst_active && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_scoreboard: unexpected grant gnt=%b, no expected entry", gnt);
        end else begin
            e = exp_q.pop_front();
            exp_g = 4'b0001 << e.id;
            if (burst_active !== 1'b1 || gnt !== exp_g || gnt_id !== ID_W'(e.id)
                || beat_cnt !== 4'd0) begin
                errors++;
                $display("FAIL grant: active=%b gnt=%b id=%0d cnt=%0d, required gnt=%b id=%0d cnt=0",
                         burst_active, gnt, gnt_id, beat_cnt, exp_g, e.id);
            end
        end
    endtask

    task automatic finish_burst();
        int n = 0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        while (burst_active && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (burst_active !== 1'b0) begin
            errors++;
            $display("FAIL finish_burst: still active after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        req        = '0;
        req_len    = '0;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        apply_reset();
        checks++;
        if (gnt !== 4'b0 || gnt_id !== 2'd0 || burst_active !== 1'b0 || burst_last !== 1'b0
            || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b id=%0d act=%b last=%b cnt=%0d, required all zero",
                     gnt, gnt_id, burst_active, burst_last, beat_cnt);
        end
        // Beat handshakes with no grant must be ignored.
        repeat (3) tick();
        checks++;
        if (gnt !== 4'b0 || burst_active !== 1'b0 || beat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL idle_ignore: gnt=%b act=%b cnt=%0d, required 0/0/0",
                     gnt, burst_active, beat_cnt);
        end
    endtask

    task automatic test_single_burst();
        int w;
        apply_reset();
        req_len[0*LEN_W +: LEN_W] = 4'd3;
        req = 4'b0001;
        exp_q.push_back('{id: 0});
        wait_grant(w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required 1", w);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (beat_cnt !== 4'(k) || burst_last !== (k == 3)) begin
                errors++;
                $display("FAIL single_beat%0d: cnt=%0d last=%b, required cnt=%0d last=%b",
                         k, beat_cnt, burst_last, k, (k == 3));
            end
            if (k == 3) req = '0;
            tick();
        end
        checks++;
        if (burst_active !== 1'b0 || gnt !== 4'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL single_end: act=%b gnt=%b id=%0d, required 0/0000/0",
                     burst_active, gnt, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        int w;
        int order[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        req_len = '0;
        req     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{id: order[i]});
            wait_grant(w);
            checks++;
            if (w != 1 || burst_last !== 1'b1) begin
                errors++;
                $display("FAIL rr_%0d: waited=%0d last=%b, required waited=1 last=1",
                         i, w, burst_last);
            end
            tick();
            checks++;
            if (burst_active !== 1'b0 || gnt !== 4'b0) begin
                errors++;
                $display("FAIL rr_idle_%0d: act=%b gnt=%b, required idle gap", i, burst_active, gnt);
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int w;
        logic [4:0] rdy   = 5'b10101;
        int         ecnt[5] = '{0, 1, 1, 2, 2};
        apply_reset();
        req_len[2*LEN_W +: LEN_W] = 4'd2;
        req = 4'b0100;
        exp_q.push_back('{id: 2});
        wait_grant(w);
        req = '0;
        beat_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            beat_ready = rdy[k];
            checks++;
            if (beat_cnt !== 4'(ecnt[k]) || burst_last !== (k >= 3) || burst_active !== 1'b1) begin
                errors++;
                $display("FAIL bp_cycle%0d: cnt=%0d last=%b act=%b, required cnt=%0d last=%b act=1",
                         k, beat_cnt, burst_last, burst_active, ecnt[k], (k >= 3));
            end
            tick();
        end
        checks++;
        if (burst_active !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: act=%b, required 0", burst_active);
        end
        beat_ready = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int w;
        apply_reset();
        req_len = {4'd3, 4'd1, 4'd1, 4'd1};
        req     = 4'b1000;
        exp_q.push_back('{id: 3});
        wait_grant(w);
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (beat_cnt !== 4'd2) begin
            errors++;
            $display("FAIL mid_cnt: cnt=%0d, required 2", beat_cnt);
        end
        req   = 4'b1111;
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0 || burst_active !== 1'b0 || beat_cnt !== 4'd0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset: gnt=%b act=%b cnt=%0d id=%0d, required all zero",
                     gnt, burst_active, beat_cnt, gnt_id);
        end
        reset = 1'b0;
        exp_q.push_back('{id: 0});
        wait_grant(w);
        req = '0;
        finish_burst();
    endtask

    task automatic test_req_drop();
        int w;
        apply_reset();
        req_len[1*LEN_W +: LEN_W] = 4'd5;
        req = 4'b0010;
        exp_q.push_back('{id: 1});
        wait_grant(w);
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        tick();
        req     = '0;
        req_len = '0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (gnt !== 4'b0010 || beat_cnt !== 4'(k) || burst_last !== (k == 5)) begin
                errors++;
                $display("FAIL drop_beat%0d: gnt=%b cnt=%0d last=%b, required 0010/%0d/%b",
                         k, gnt, beat_cnt, burst_last, k, (k == 5));
            end
            tick();
        end
        checks++;
        if (burst_active !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL drop_end: act=%b gnt=%b, required idle", burst_active, gnt);
        end
    endtask

`ifdef BURST_ARB_STATS_EN
    task automatic test_stats();
        int w;
        apply_reset();
        req_len = '0;
        req     = 4'b0100;
        beat_valid = 1'b1;
        beat_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{id: 2});
            wait_grant(w);
            if (i == 2) req = '0;
            tick();
        end
        tick();
        checks++;
        if (burst_count !== {16'd0, 16'd3, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL stats_count: burst_count=%h, required 0000000300000000", burst_count);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_len    = '0;
        beat_valid = 1'b0;
        beat_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_reset_mid_burst();
        test_req_drop();
`ifdef BURST_ARB_STATS_EN
        test_stats();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
